// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a registered result.
// Define ALU_MUL_EN to build the iterative shift-add multiplier; otherwise MUL is an illegal op.
module alu_mc #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [3:0]      alu_ctrl,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            err,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and a producer holds its data until taken.

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SLL  = 4'b1010;
  localparam logic [3:0] OP_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] op_res;
  logic            op_legal;
  logic            accept;

`ifdef ALU_MUL_EN
  logic            op_is_mul;
  logic [XLEN-1:0] mul_a;
  logic [XLEN-1:0] mul_b;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;
  logic [SHW-1:0]  cnt;

  // One multiplier bit per cycle: mul_a walks left while mul_b walks right.
  assign acc_next = acc + (mul_b[0] ? mul_a : '0);
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Single-cycle datapath; illegal ops fall through with a zero result.
  always_comb begin
    op_res   = '0;
    op_legal = 1'b1;
`ifdef ALU_MUL_EN
    op_is_mul = 1'b0;
`endif
    case (alu_ctrl)
      OP_ADD:  op_res = A + B;
      OP_SUB:  op_res = A - B;
      OP_AND:  op_res = A & B;
      OP_OR:   op_res = A | B;
      OP_XOR:  op_res = A ^ B;
      OP_SRL:  op_res = A >> B[SHW-1:0];
      OP_SLL:  op_res = A << B[SHW-1:0];
      OP_SRA:  op_res = $unsigned($signed(A) >>> B[SHW-1:0]);
      OP_SLT:  op_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: op_res = {{(XLEN-1){1'b0}}, (A < B)};
      OP_MUL: begin
`ifdef ALU_MUL_EN
        op_is_mul = 1'b1;
`else
        op_legal  = 1'b0;
`endif
      end
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      err       <= 1'b0;
`ifdef ALU_MUL_EN
      cnt       <= '0;
      acc       <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_MUL_EN
            if (op_is_mul) begin
              state     <= BUSY;
              out_valid <= 1'b0;
              mul_a     <= A;
              mul_b     <= B;
              acc       <= '0;
              cnt       <= '0;
            end else
`endif
            begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op_res;
              zero      <= (op_res == '0);
              err       <= ~op_legal;
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
`ifdef ALU_MUL_EN
          acc   <= acc_next;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == SHW'(XLEN - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= acc_next;
            zero      <= (acc_next == '0);
            err       <= 1'b0;
            cnt       <= '0;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed table, hand-written handshake/flush/reset sequences and
// randomized traffic scored against an arithmetic model with a latency-tagged queue.
module tb_alu_mc;
  localparam int XLEN = 32;
  localparam int W    = XLEN + 2;
`ifdef ALU_MUL_EN
  localparam int MUL_LAT = XLEN + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready, zero, err;
  logic [XLEN-1:0] A, B, result;
  logic [3:0]      alu_ctrl;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Scoreboard entries are {err, zero, result}, tagged with the cycle they become visible.
  logic [W-1:0] exp_q[$];
  int           due_q[$];

  logic            seen_ov, seen_ir, seen_z, seen_e;
  logic [XLEN-1:0] seen_res;

  alu_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_ctrl(alu_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
    longint          sa, sb, p2s;
    longint unsigned ua, ub, p2, r;
    logic            e;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = 64'(a);
    ub  = 64'(b);
    p2  = 64'd1 << b[4:0];
    p2s = longint'(p2);
    r   = 0;
    e   = 1'b0;
    case (op)
      4'b0000: r = ua + ub;
      4'b0001: r = ua - ub;
      4'b0010: r = ua & ub;
      4'b0100: r = ua | ub;
      4'b1000: r = ua ^ ub;
      4'b1001: r = ua / p2;
      4'b1010: r = ua * p2;
      4'b1011: r = (sa >= 0) ? longint'(sa / p2s) : -((-sa + p2s - 1) / p2s);
      4'b0011: r = (sa < sb) ? 64'd1 : 64'd0;
      4'b0101: r = (ua < ub) ? 64'd1 : 64'd0;
`ifdef ALU_MUL_EN
      4'b0110: r = ua * ub;
`endif
      default: e = 1'b1;
    endcase
    if (e) r = 0;
    return {e, (r[XLEN-1:0] == '0), r[XLEN-1:0]};
  endfunction

  function automatic int model_lat(input logic [3:0] op);
    return (op == 4'b0110) ? MUL_LAT : 1;
  endfunction

  // ---------------- driver + scoreboard ----------------
  // One clock cycle: drive on the falling edge, then compare the handshake and data
  // the model predicts before the next rising edge commits anything.
  task automatic step(input logic iv, input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic ordy,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    logic exp_ov, exp_ir;
    @(negedge clk);
    in_valid = iv; alu_ctrl = op; A = a; B = b; out_ready = ordy; flush = fl; rst = rs;
    #1;
    seen_ov = out_valid; seen_ir = in_ready; seen_res = result; seen_z = zero; seen_e = err;
    exp_ov = (exp_q.size() != 0) && (cyc >= due_q[0]);
    exp_ir = (exp_q.size() == 0) || (exp_ov && ordy);
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("in_ready", 64'(in_ready), 64'(exp_ir));
    if (exp_ov) begin
      chk("result_data", 64'({err, zero, result}), 64'(exp_q[0]));
      if (ordy) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
    if (rs || fl) begin
      exp_q.delete();
      due_q.delete();
    end else if (iv && exp_ir) begin
      exp_q.push_back(model(op, a, b));
      due_q.push_back(cyc + model_lat(op));
    end
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'b0000, '0, '0, ordy);
  endtask

  // Issue one op with out_ready high and wait (bounded) for its result.
  task automatic run_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output logic [XLEN-1:0] res, output logic z, output logic e,
                        output int lat);
    step(1'b1, op, a, b, 1'b1);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      idle(1'b1);
      if (seen_ov) begin
        lat = k;
        break;
      end
    end
    res = seen_res; z = seen_z; e = seen_e;
    if (lat == 0) chk("result_timeout", 64'(0), 64'(1));
  endtask

  function automatic logic [XLEN-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return XLEN'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- tests ----------------
  typedef struct {
    logic [3:0]      op;
    logic [XLEN-1:0] a, b, res;
    logic            z, e;
    int              lat;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [XLEN-1:0] r;
    logic            z, e;
    int              lat;

    tbl[0]  = '{4'b0000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1};
    tbl[1]  = '{4'b0001, 32'd3,         32'd3,         32'd0,         1'b1, 1'b0, 1};
    tbl[2]  = '{4'b1011, 32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0, 1'b0, 1};
    tbl[3]  = '{4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0, 1};
    tbl[4]  = '{4'b0101, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 1};
    tbl[5]  = '{4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'b0100, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'b1000, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'b1001, 32'h8000_0010, 32'h104,       32'h0800_0001, 1'b0, 1'b0, 1};
    tbl[9]  = '{4'b1010, 32'h0000_0003, 32'h3F,        32'h8000_0000, 1'b0, 1'b0, 1};
    tbl[10] = '{4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0,         1'b1, 1'b1, 1};
    tbl[11] = '{4'b0000, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0, 1};
`ifdef ALU_MUL_EN
    tbl[12] = '{4'b0110, 32'd6,         32'd7,         32'd42,        1'b0, 1'b0, XLEN + 1};
    tbl[13] = '{4'b0110, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFE, 1'b0, 1'b0, XLEN + 1};
`else
    tbl[12] = '{4'b0110, 32'd6,         32'd7,         32'd0,         1'b1, 1'b1, 1};
    tbl[13] = '{4'b0110, 32'hFFFF_FFFF, 32'd2,         32'd0,         1'b1, 1'b1, 1};
`endif

    do_reset();
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_result", 64'(result), 64'(0));
    chk("reset_zero", 64'(zero), 64'(0));
    chk("reset_err", 64'(err), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Directed table
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, e, lat);
      chk($sformatf("tbl%0d_result", i), 64'(r), 64'(tbl[i].res));
      chk($sformatf("tbl%0d_zero", i), 64'(z), 64'(tbl[i].z));
      chk($sformatf("tbl%0d_err", i), 64'(e), 64'(tbl[i].e));
      chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Back-to-back ADDs: one result per cycle, in_ready held high
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'b0000, XLEN'(i * 100), XLEN'(i), 1'b1);
      if (i > 0) chk("b2b_result", 64'(seen_res), 64'((i - 1) * 101));
      chk("b2b_in_ready", 64'(seen_ir), 64'(1));
    end
    idle(1'b1);

    // Consumer stall for 3 cycles while a new op is offered
    step(1'b1, 4'b0001, 32'd50, 32'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000, 32'd1, 32'd2, 1'b0);
      chk("stall_result", 64'(seen_res), 64'(42));
      chk("stall_in_ready", 64'(seen_ir), 64'(0));
    end
    step(1'b1, 4'b0000, 32'd1, 32'd2, 1'b1);
    chk("stall_release_in_ready", 64'(seen_ir), 64'(1));
    idle(1'b1);
    chk("stall_next_result", 64'(seen_res), 64'(3));
    idle(1'b1);

    // Flush on the tenth busy cycle of a multiply
    step(1'b1, 4'b0110, 32'd6, 32'd7, 1'b1);
    repeat (9) idle(1'b1);
    step(1'b0, 4'b0000, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) idle(1'b1);
    chk("flush_result", 64'(seen_res), 64'(0));
    chk("flush_zero", 64'(seen_z), 64'(0));
    chk("flush_err", 64'(seen_e), 64'(0));
    run_op(4'b0000, 32'd100, 32'd23, r, z, e, lat);
    chk("post_flush_add", 64'(r), 64'(123));

    // Reset while a result is waiting in DONE
    step(1'b1, 4'b0000, 32'd9, 32'd9, 1'b0);
    idle(1'b0);
    step(1'b0, 4'b0000, '0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_done_out_valid", 64'(seen_ov), 64'(0));
    chk("rst_done_result", 64'(seen_res), 64'(0));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
    end
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
